// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory controller and the L1 D-cache:
// line geometry, address field widths, FSM state and operation encodings.
package mem_pkg;

    localparam int WORDS_PER_LINE   = 8;
    localparam int BYTE_OFFSET_BITS = 2;
    localparam int LINE_OFFSET_BITS = $clog2(WORDS_PER_LINE);
    localparam int OFFSET_BITS      = BYTE_OFFSET_BITS + LINE_OFFSET_BITS;

    // L1 geometry used to split a 32-bit byte address into tag/index/offset
    localparam int L1_LINES   = 16;
    localparam int INDEX_BITS = $clog2(L1_LINES);
    localparam int TAG_BITS   = 32 - INDEX_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        WRITE
    } mem_state_t;

    typedef enum logic {
        OP_LOAD,
        OP_STORE
    } mem_op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port 32-bit backing store: synchronous write, one-cycle registered read.
// Contents are deliberately not reset.
module mem_array #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory controller serving L1 D-cache line fills and single-word stores
// after a fixed access latency.
module main_mem_ctrl #(
    parameter int MEM_WORDS      = 1024,
    parameter int WORDS_PER_LINE = 8,
    parameter int ACCESS_LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        VALID,
    output logic        READY,
    input  logic        LOAD,
    input  logic        STORE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        RVALID,
    output logic [2:0]  WORD_IDX,
    output logic        DONE
);

    import mem_pkg::*;

    localparam int AW = $clog2(MEM_WORDS);
    localparam int LW = LINE_OFFSET_BITS;

    localparam logic [3:0]    LATENCY   = 4'(ACCESS_LATENCY);
    localparam logic [LW-1:0] LAST_BEAT = LW'(WORDS_PER_LINE - 1);
    localparam logic [LW-1:0] BEAT_ONE  = LW'(1);

    mem_state_t    state;
    mem_op_t       op_q;
    logic [AW-1:0] word_addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    lat_cnt;
    logic [LW-1:0] beat_q;
    logic          rvalid_q;
    logic          done_q;
    logic          ready_q;

    logic [LW-1:0]    next_beat;
    logic [AW-LW-1:0] line_sel;
    logic [AW-1:0]    ram_addr;
    logic             ram_we;
    logic [31:0]      ram_rdata;

    // Byte offset and bits above the backing-store depth are dropped on purpose
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ADDR[31:AW+2], ADDR[1:0]};

    assign next_beat = beat_q + BEAT_ONE;
    assign line_sel  = word_addr_q[AW-1:LW];
    assign ram_we    = (state == WRITE);

    // RAM read is registered, so each beat's address goes out one cycle early:
    // line base during WAIT, then base+k+1 while beat k is on the bus.
    always_comb begin
        ram_addr = word_addr_q;
        case (state)
            WAIT:    ram_addr = {line_sel, {LW{1'b0}}};
            BURST:   ram_addr = {line_sel, next_beat};
            default: ram_addr = word_addr_q;
        endcase
    end

    mem_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_mem_array (
        .CLK   (CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            op_q        <= OP_LOAD;
            word_addr_q <= '0;
            wdata_q     <= '0;
            lat_cnt     <= '0;
            beat_q      <= '0;
            rvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (VALID && (LOAD ^ STORE)) begin
                        op_q        <= LOAD ? OP_LOAD : OP_STORE;
                        word_addr_q <= ADDR[AW+1:2];
                        wdata_q     <= WDATA;
                        lat_cnt     <= LATENCY;
                        ready_q     <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd1) begin
                        lat_cnt <= '0;
                        if (op_q == OP_LOAD) begin
                            state    <= BURST;
                            rvalid_q <= 1'b1;
                            beat_q   <= '0;
                        end else begin
                            state  <= WRITE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                BURST: begin
                    if (beat_q == LAST_BEAT) begin
                        state    <= IDLE;
                        rvalid_q <= 1'b0;
                        beat_q   <= '0;
                        done_q   <= 1'b0;
                        ready_q  <= 1'b1;
                    end else begin
                        beat_q <= next_beat;
                        done_q <= (next_beat == LAST_BEAT);
                    end
                end
                WRITE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign READY    = ready_q;
    assign RVALID   = rvalid_q;
    assign DONE     = done_q;
    assign WORD_IDX = 3'(beat_q);
    assign RDATA    = rvalid_q ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: directed scenarios plus random traffic
// compared against a word-array memory model and the fill/store timing rules.
module tb_main_mem_ctrl;

    localparam int MEM_WORDS = 1024;
    localparam int LPW       = 8;
    localparam int LAT       = 4;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b1;
    logic        VALID = 1'b0;
    logic        LOAD  = 1'b0;
    logic        STORE = 1'b0;
    logic [31:0] ADDR  = 32'd0;
    logic [31:0] WDATA = 32'd0;
    logic        READY;
    logic [31:0] RDATA;
    logic        RVALID;
    logic [2:0]  WORD_IDX;
    logic        DONE;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [MEM_WORDS];
    bit          known     [MEM_WORDS];

    main_mem_ctrl #(
        .MEM_WORDS      (MEM_WORDS),
        .WORDS_PER_LINE (LPW),
        .ACCESS_LATENCY (LAT)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .VALID    (VALID),
        .READY    (READY),
        .LOAD     (LOAD),
        .STORE    (STORE),
        .ADDR     (ADDR),
        .WDATA    (WDATA),
        .RDATA    (RDATA),
        .RVALID   (RVALID),
        .WORD_IDX (WORD_IDX),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % MEM_WORDS);
    endfunction

    task automatic check_idle(input string tag);
        check_output({tag, " ready"},    32'(READY),    32'd1);
        check_output({tag, " rvalid"},   32'(RVALID),   32'd0);
        check_output({tag, " done"},     32'(DONE),     32'd0);
        check_output({tag, " word_idx"}, 32'(WORD_IDX), 32'd0);
        check_output({tag, " rdata"},    RDATA,         32'd0);
    endtask

    task automatic scramble_inputs();
        VALID = 1'($urandom_range(0, 1));
        LOAD  = 1'($urandom_range(0, 1));
        STORE = 1'($urandom_range(0, 1));
        ADDR  = $urandom;
        WDATA = $urandom;
    endtask

    task automatic quiet_inputs();
        VALID = 1'b0;
        LOAD  = 1'b0;
        STORE = 1'b0;
    endtask

    task automatic apply_stimulus(input bit is_load, input logic [31:0] addr,
                                  input logic [31:0] wdata);
        check_output("accept ready", 32'(READY), 32'd1);
        VALID = 1'b1;
        LOAD  = is_load;
        STORE = !is_load;
        ADDR  = addr;
        WDATA = wdata;
        tick();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            scramble_inputs();
            tick();
        end
    endtask

    task automatic do_load(input logic [31:0] addr);
        int base;
        base = word_of(addr) - (word_of(addr) % LPW);
        apply_stimulus(1'b1, addr, $urandom);
        for (int i = 1; i <= LAT; i++) begin
            scramble_inputs();
            check_output("load wait rvalid", 32'(RVALID), 32'd0);
            check_output("load wait done",   32'(DONE),   32'd0);
            check_output("load wait ready",  32'(READY),  32'd0);
            check_output("load wait rdata",  RDATA,       32'd0);
            tick();
        end
        for (int k = 0; k < LPW; k++) begin
            scramble_inputs();
            check_output($sformatf("load beat%0d rvalid", k), 32'(RVALID), 32'd1);
            check_output($sformatf("load beat%0d idx", k), 32'(WORD_IDX), 32'(k));
            check_output($sformatf("load beat%0d done", k), 32'(DONE), 32'(k == LPW - 1));
            check_output($sformatf("load beat%0d ready", k), 32'(READY), 32'd0);
            if (known[base + k]) begin
                check_output($sformatf("load beat%0d rdata (word 0x%0h)", k, base + k),
                             RDATA, model_mem[base + k]);
            end
            tick();
        end
        quiet_inputs();
        check_idle("load end");
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] wdata);
        apply_stimulus(1'b0, addr, wdata);
        for (int i = 1; i <= LAT; i++) begin
            scramble_inputs();
            check_output("store wait done",   32'(DONE),   32'd0);
            check_output("store wait ready",  32'(READY),  32'd0);
            check_output("store wait rvalid", 32'(RVALID), 32'd0);
            tick();
        end
        scramble_inputs();
        check_output("store write done",   32'(DONE),   32'd1);
        check_output("store write ready",  32'(READY),  32'd0);
        check_output("store write rvalid", 32'(RVALID), 32'd0);
        check_output("store write rdata",  RDATA,       32'd0);
        tick();
        quiet_inputs();
        check_idle("store end");
        model_mem[word_of(addr)] = wdata;
        known[word_of(addr)]     = 1'b1;
    endtask

    task automatic pulse_reset_now(input string tag);
        #1 RST_N = 1'b0;
        quiet_inputs();
        #1 check_idle({tag, " immediate"});
        tick();
        RST_N = 1'b1;
        check_idle({tag, " released"});
    endtask

    initial begin
        logic [31:0] addr;
        int          word;

        $display("[TB] power-on reset");
        #2 RST_N = 1'b0;
        #1 check_idle("reset");
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        check_idle("post reset");

        $display("[TB] store then load of the same line");
        do_store(32'h0000_0104, 32'hDEAD_BEEF);
        do_load(32'h0000_0100);

        $display("[TB] preload line 0x40 and fill from an unaligned address");
        for (int i = 0; i < LPW; i++) begin
            do_store(32'((32'h40 + i) << 2), 32'h1000 + 32'(i));
        end
        do_load(32'h0000_011C);

        $display("[TB] illegal requests are ignored");
        VALID = 1'b1; LOAD = 1'b1; STORE = 1'b1;
        ADDR = 32'h0000_0104; WDATA = 32'h0BAD_0BAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("illegal both");
        end
        LOAD = 1'b0; STORE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("illegal none");
        end
        quiet_inputs();
        do_load(32'h0000_0100);

        $display("[TB] address wrap modulo MEM_WORDS");
        do_store(32'h0000_1004, 32'hCAFE_0001);
        do_load(32'h0000_0004);

        $display("[TB] reset during beat 3 of a fill");
        apply_stimulus(1'b1, 32'h0000_011C, 32'd0);
        run_cycles(LAT + 3);
        check_output("abort fill at beat3 rvalid", 32'(RVALID), 32'd1);
        check_output("abort fill at beat3 idx", 32'(WORD_IDX), 32'd3);
        pulse_reset_now("reset in fill");
        for (int i = 0; i < 12; i++) begin
            tick();
            check_output("after fill abort rvalid", 32'(RVALID), 32'd0);
            check_output("after fill abort done",   32'(DONE),   32'd0);
            check_output("after fill abort ready",  32'(READY),  32'd1);
        end

        $display("[TB] reset during WAIT and during WRITE of a store");
        apply_stimulus(1'b0, 32'h0000_0108, 32'hBAD0_BAD0);
        run_cycles(2);
        check_output("abort store in wait ready", 32'(READY), 32'd0);
        pulse_reset_now("reset in store wait");
        do_load(32'h0000_0100);
        apply_stimulus(1'b0, 32'h0000_010C, 32'hBAD1_BAD1);
        run_cycles(LAT);
        check_output("abort store in write done", 32'(DONE), 32'd1);
        pulse_reset_now("reset in store write");
        do_load(32'h0000_0100);

        $display("[TB] random traffic");
        for (int w = 0; w < 32; w++) begin
            do_store(32'(w) << 2, $urandom);
        end
        for (int n = 0; n < 24; n++) begin
            word = $urandom_range(0, 31);
            addr = ($urandom & 32'hFFFF_F003) | (32'(word) << 2);
            if ($urandom_range(0, 3) == 0) begin
                VALID = 1'b1;
                LOAD  = 1'($urandom_range(0, 1));
                STORE = LOAD;
                ADDR  = addr;
                tick();
                quiet_inputs();
                check_idle("random illegal");
            end
            if ($urandom_range(0, 1) == 1) begin
                do_store(addr, $urandom);
            end else begin
                do_load(addr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
